// File: rtl/liteic_slave_read_arbiter.sv
// Round-robin read-channel arbiter sharing one AXI-Lite slave AR/R port among NUM_MASTERS crossbar masters.
// Optional macro LITEIC_SLV_RD_ARB_RESP_REG_EN inserts a one-beat registered response slice.
module liteic_slave_read_arbiter #(
   parameter int NUM_MASTERS  = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int RDATA_WIDTH  = 34,
   parameter int MST_ID_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [NUM_MASTERS-1:0]  cbar_reqst_val_i,
   input  logic [ADDR_WIDTH-1:0]   cbar_reqst_data_i [NUM_MASTERS],
   output logic [NUM_MASTERS-1:0]  cbar_reqst_rdy_o,
   output logic [NUM_MASTERS-1:0]  cbar_resp_val_o,
   input  logic [NUM_MASTERS-1:0]  cbar_resp_rdy_i,
   output logic [RDATA_WIDTH-1:0]  cbar_resp_data_o,
   output logic                    slv_ar_valid_o,
   output logic [ADDR_WIDTH-1:0]   slv_ar_addr_o,
   input  logic                    slv_ar_ready_i,
   input  logic                    slv_r_valid_i,
   input  logic [RDATA_WIDTH-3:0]  slv_r_data_i,
   input  logic [1:0]              slv_r_resp_i,
   output logic                    slv_r_ready_o,
   output logic [MST_ID_WIDTH-1:0] grant_id_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [MST_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [MST_ID_WIDTH-1:0] grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;

   logic [NUM_MASTERS-1:0]  grant_oh;
   logic                    sel_resp_rdy;
   logic [MST_ID_WIDTH-1:0] grant_inc;
   logic                    arb_found;
   logic [MST_ID_WIDTH-1:0] arb_id;
   logic [ADDR_WIDTH-1:0]   arb_addr;
   int                      arb_hi, arb_lo, arb_win;

`ifdef LITEIC_SLV_RD_ARB_RESP_REG_EN
   logic                    slice_full_q, slice_full_d;
   logic [RDATA_WIDTH-1:0]  slice_data_q, slice_data_d;
`endif

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant_oh
         assign grant_oh[gi] = (grant_q == MST_ID_WIDTH'(gi));
      end
   endgenerate

   assign sel_resp_rdy = |(cbar_resp_rdy_i & grant_oh);
   assign grant_id_o   = grant_q;
   assign slv_ar_addr_o = ar_addr_q;

   // Descending scan: arb_lo ends on the lowest requester, arb_hi on the lowest at/above the pointer.
   always_comb begin
      arb_hi   = -1;
      arb_lo   = -1;
      arb_addr = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (cbar_reqst_val_i[i]) begin
            arb_lo = i;
            if (i >= int'(rr_ptr_q)) begin
               arb_hi = i;
            end
         end
      end
      arb_win   = (arb_hi >= 0) ? arb_hi : arb_lo;
      arb_found = (arb_lo >= 0);
      arb_id    = MST_ID_WIDTH'(arb_win);
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (i == arb_win) begin
            arb_addr = cbar_reqst_data_i[i];
         end
      end
   end

   always_comb begin
      if (int'(grant_q) >= NUM_MASTERS - 1) begin
         grant_inc = '0;
      end else begin
         grant_inc = grant_q + MST_ID_WIDTH'(1);
      end
   end

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      grant_d          = grant_q;
      ar_addr_d        = ar_addr_q;
      slv_ar_valid_o   = 1'b0;
      cbar_reqst_rdy_o = '0;
      cbar_resp_val_o  = '0;
      cbar_resp_data_o = '0;
      slv_r_ready_o    = 1'b0;
`ifdef LITEIC_SLV_RD_ARB_RESP_REG_EN
      slice_full_d     = slice_full_q;
      slice_data_d     = slice_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d   = arb_id;
               ar_addr_d = arb_addr;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            slv_ar_valid_o = 1'b1;
            if (slv_ar_ready_i) begin
               cbar_reqst_rdy_o = grant_oh;
               state_d          = RESP;
            end
         end
         RESP: begin
`ifdef LITEIC_SLV_RD_ARB_RESP_REG_EN
            // Slave side only ever sees ready from the slice, never from the master.
            slv_r_ready_o = ~slice_full_q;
            if (slice_full_q) begin
               cbar_resp_val_o  = grant_oh;
               cbar_resp_data_o = slice_data_q;
               if (sel_resp_rdy) begin
                  slice_full_d = 1'b0;
                  slice_data_d = '0;
                  rr_ptr_d     = grant_inc;
                  state_d      = IDLE;
               end
            end else if (slv_r_valid_i) begin
               slice_full_d = 1'b1;
               slice_data_d = {slv_r_data_i, slv_r_resp_i};
            end
`else
            slv_r_ready_o    = sel_resp_rdy;
            cbar_resp_data_o = {slv_r_data_i, slv_r_resp_i};
            if (slv_r_valid_i) begin
               cbar_resp_val_o = grant_oh;
               if (sel_resp_rdy) begin
                  rr_ptr_d = grant_inc;
                  state_d  = IDLE;
               end
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         ar_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         ar_addr_q <= ar_addr_d;
      end
   end

`ifdef LITEIC_SLV_RD_ARB_RESP_REG_EN
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         slice_full_q <= 1'b0;
         slice_data_q <= '0;
      end else begin
         slice_full_q <= slice_full_d;
         slice_data_q <= slice_data_d;
      end
   end
`endif

endmodule
